// File: rtl/sdrd_deserializer_if.sv
// -----------------------------------------------------------------------------
// sdrd_deserializer_if
//   Groups the serial receive line, the host read port and the error flags of
//   the SDRD deserializer so they travel as one bundle.
//
//   Signals (direction seen from the deserializer, i.e. the slave modport):
//     SDRD      in   1  serial data, already synchronised to clk
//     sd_stb    in   1  bit strobe, 1-cycle pulse; SDRD valid on this cycle
//     sd_abort  in   1  level: force abort of the frame in progress
//     rd_stb    in   1  1-cycle pulse: pop FIFO head
//     err_clr   in   1  1-cycle pulse: clear ovf and ferr
//     rd_data   out  8  FIFO head byte, zero-extended; 0 when empty
//     rd_empty  out  1  FIFO empty
//     rd_full   out  1  FIFO full
//     ovf       out  1  sticky: completed byte dropped on a full FIFO
//     ferr      out  1  sticky: frame aborted (timeout, sd_abort, parity)
//
//   master: the side driving the strobes and reading the FIFO (decoder/host).
//   slave : the deserializer itself.
// -----------------------------------------------------------------------------
interface sdrd_deserializer_if;
    logic       SDRD;
    logic       sd_stb;
    logic       sd_abort;
    logic       rd_stb;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic       rd_full;
    logic       ovf;
    logic       ferr;

    modport master (
        output SDRD, sd_stb, sd_abort, rd_stb, err_clr,
        input  rd_data, rd_empty, rd_full, ovf, ferr
    );

    modport slave (
        input  SDRD, sd_stb, sd_abort, rd_stb, err_clr,
        output rd_data, rd_empty, rd_full, ovf, ferr
    );
endinterface

// File: rtl/sdrd_deserializer.sv
// -----------------------------------------------------------------------------
// sdrd_deserializer
//   Receives LSB-first frames from the CLE162 serial read line (SDRD), one bit
//   per qualified strobe, assembles them into bytes and queues completed bytes
//   in a small first-word-fall-through FIFO read by the host with a pop pulse.
//
//   Ports:
//     clk    in  system clock, all state updates on posedge
//     rst_n  in  asynchronous active-low reset
//     bus    sdrd_deserializer_if.slave (serial input, read port, error flags)
//
//   Parameters:
//     FIFO_DEPTH  entries in the byte FIFO, power of two, 2..16
//     BITS        data bits per frame, 4..8
//     TIMEOUT     idle clocks tolerated between bits mid-frame, 1..1023
//
//   Build option:
//     SDRD_PARITY_EN  when defined, every frame carries one odd-parity bit after
//                     the data bits and a parity mismatch sets ferr. When not
//                     defined the PARITY state does not exist and a frame is
//                     exactly BITS strobes.
// -----------------------------------------------------------------------------
module sdrd_deserializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int BITS       = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    sdrd_deserializer_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);       // FIFO pointer width
    localparam int CW = $clog2(FIFO_DEPTH) + 1;   // occupancy width, holds DEPTH
    localparam int TW = $clog2(TIMEOUT + 1);      // inter-bit timer width
    localparam int NW = $clog2(BITS + 1);         // bit counter width, holds BITS

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef SDRD_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_PUSH   = 2'd3
    } state_t;

    // Frame assembly state
    state_t          r_state;
    logic [BITS-1:0] r_shift;
    logic [NW-1:0]   r_bitcnt;
    logic [TW-1:0]   r_timer;
    logic            r_ferr;
    logic            r_ovf;

    // FIFO state
    logic [BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [BITS-1:0] w_shift_next;
    logic [7:0]      w_rd_data;
    logic            w_last_bit;
    logic            w_timeout;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));

    // A pop on an empty FIFO is simply ignored.
    assign w_pop   = bus.rd_stb && !w_empty;

    // The completed byte is accepted when there is room, or when a pop in the
    // same cycle frees the slot it will occupy.
    assign w_push  = (r_state == ST_PUSH) && (!w_full || w_pop);

    assign w_last_bit = (r_bitcnt == NW'(BITS - 1));
    assign w_timeout  = (r_timer == TW'(TIMEOUT));

`ifdef SDRD_PARITY_EN
    logic w_par_ok;
    // Odd parity: data bits plus parity bit hold an odd number of ones.
    assign w_par_ok = ^{r_shift, bus.SDRD};
`endif

    // Shift register with SDRD written into the slot selected by the bit count.
    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        w_shift_next = r_shift;
        for (int k = 0; k < BITS; k++) begin
            if (r_bitcnt == NW'(k)) begin
                w_shift_next[k] = bus.SDRD;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM and sticky error flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_timer  <= '0;
            r_ferr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            // Clear first; an error event later in this block overrides it.
            if (bus.err_clr) begin
                r_ferr <= 1'b0;
                r_ovf  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // sd_abort is meaningless without a frame in progress.
                    if (bus.sd_stb) begin
                        r_shift  <= {{(BITS-1){1'b0}}, bus.SDRD};
                        r_bitcnt <= NW'(1);
                        r_timer  <= '0;
                        r_state  <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (bus.sd_abort || (!bus.sd_stb && w_timeout)) begin
                        r_ferr   <= 1'b1;
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_timer  <= '0;
                        r_state  <= ST_IDLE;
                    end else if (bus.sd_stb) begin
                        r_shift  <= w_shift_next;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_timer  <= '0;
                        if (w_last_bit) begin
`ifdef SDRD_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_PUSH;
`endif
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

`ifdef SDRD_PARITY_EN
                ST_PARITY: begin
                    if (bus.sd_abort || (!bus.sd_stb && w_timeout)
                        || (bus.sd_stb && !w_par_ok)) begin
                        r_ferr   <= 1'b1;
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_timer  <= '0;
                        r_state  <= ST_IDLE;
                    end else if (bus.sd_stb) begin
                        r_timer <= '0;
                        r_state <= ST_PUSH;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif

                ST_PUSH: begin
                    // The FIFO writes r_shift this cycle; a refused write is
                    // recorded as an overflow and the byte is lost.
                    if (!w_push) begin
                        r_ovf <= 1'b1;
                    end
                    r_timer <= '0;
                    // A strobe here already belongs to the next frame.
                    if (bus.sd_stb) begin
                        r_shift  <= {{(BITS-1){1'b0}}, bus.SDRD};
                        r_bitcnt <= NW'(1);
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_shift  <= '0;
                    r_bitcnt <= '0;
                    r_timer  <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy gates every read, so
    // stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // First-word-fall-through head, forced to zero while empty.
    always_comb begin
        w_rd_data = '0;
        if (!w_empty) begin
            w_rd_data[BITS-1:0] = r_mem[r_rd_ptr];
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_empty = w_empty;
    assign bus.rd_full  = w_full;
    assign bus.ovf      = r_ovf;
    assign bus.ferr     = r_ferr;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sdrd_deserializer
//   Directed bench for sdrd_deserializer (FIFO_DEPTH=4, BITS=8, TIMEOUT=255).
//   Status is compared as a 12-bit word {rd_empty, rd_full, ovf, ferr, rd_data}
//   so in hex the top nibble reads empty=8, full=4, ovf=2, ferr=1.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sdrd_deserializer;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdrd_deserializer_if ifc ();

    sdrd_deserializer #(
        .FIFO_DEPTH (4),
        .BITS       (8),
        .TIMEOUT    (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    function automatic logic [11:0] st();
        return {ifc.rd_empty, ifc.rd_full, ifc.ovf, ifc.ferr, ifc.rd_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        ifc.SDRD   = b;
        ifc.sd_stb = 1'b1;
        tick();
        ifc.sd_stb = 1'b0;
        ifc.SDRD   = 1'b0;
    endtask

    // Data bits LSB first, then the odd-parity bit when parity is built in.
    // Returns one clock after the final strobe, i.e. in the PUSH cycle.
    task automatic send_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SDRD_PARITY_EN
        send_bit(~^d);
`endif
    endtask

    task automatic pop();
        ifc.rd_stb = 1'b1;
        tick();
        ifc.rd_stb = 1'b0;
    endtask

    task automatic clear_err();
        ifc.err_clr = 1'b1;
        tick();
        ifc.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL reset_initial: got %h expected %h", st(), 12'h800);
        end
        rst_n = 1'b1;
        tick();
        // Put the block in a non-reset state: one byte queued, ferr set.
        send_frame(8'h96);
        tick();
        send_bit(1'b1);
        ifc.sd_abort = 1'b1;
        tick();
        ifc.sd_abort = 1'b0;
        n_checks++;
        if (st() !== 12'h196) begin
            n_errors++;
            $display("FAIL reset_prestate: got %h expected %h", st(), 12'h196);
        end
        // Three bits into a frame, then reset with no clock edge.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", st(), 12'h800);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'hC3);
        tick();
        n_checks++;
        if (st() !== 12'h0C3) begin
            n_errors++;
            $display("FAIL reset_clean_frame: got %h expected %h", st(), 12'h0C3);
        end
        pop();
    endtask

    task automatic test_frame();
        send_frame(8'hA5);
        // PUSH cycle: byte not yet visible.
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL frame_latency: got %h expected %h", st(), 12'h800);
        end
        tick();
        n_checks++;
        if (st() !== 12'h0A5) begin
            n_errors++;
            $display("FAIL frame_data: got %h expected %h", st(), 12'h0A5);
        end
        pop();
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL frame_pop: got %h expected %h", st(), 12'h800);
        end
    endtask

    task automatic test_empty_pop();
        pop();
        pop();
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL empty_pop: got %h expected %h", st(), 12'h800);
        end
        send_frame(8'h0F);
        tick();
        n_checks++;
        if (st() !== 12'h00F) begin
            n_errors++;
            $display("FAIL empty_pop_then_push: got %h expected %h", st(), 12'h00F);
        end
        pop();
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL empty_pop_drain: got %h expected %h", st(), 12'h800);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] exp;
        // Back to back: each next frame's first strobe lands in the PUSH cycle.
        for (int v = 1; v <= 5; v++) send_frame(8'(v));
        n_checks++;
        if (st() !== 12'h401) begin
            n_errors++;
            $display("FAIL ovf_full: got %h expected %h", st(), 12'h401);
        end
        tick();
        n_checks++;
        if (st() !== 12'h601) begin
            n_errors++;
            $display("FAIL ovf_set: got %h expected %h", st(), 12'h601);
        end
        for (int k = 1; k <= 4; k++) begin
            exp = {1'b0, (k == 1), 1'b1, 1'b0, 8'(k)};
            n_checks++;
            if (st() !== exp) begin
                n_errors++;
                $display("FAIL ovf_read%0d: got %h expected %h", k, st(), exp);
            end
            pop();
        end
        n_checks++;
        if (st() !== 12'hA00) begin
            n_errors++;
            $display("FAIL ovf_drained: got %h expected %h", st(), 12'hA00);
        end
        clear_err();
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL ovf_clear: got %h expected %h", st(), 12'h800);
        end
    endtask

    task automatic test_timeout();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(255);
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL timeout_early: got %h expected %h", st(), 12'h800);
        end
        idle(1);
        n_checks++;
        if (st() !== 12'h900) begin
            n_errors++;
            $display("FAIL timeout_ferr: got %h expected %h", st(), 12'h900);
        end
        send_frame(8'h3C);
        tick();
        n_checks++;
        if (st() !== 12'h13C) begin
            n_errors++;
            $display("FAIL timeout_recover: got %h expected %h", st(), 12'h13C);
        end
        clear_err();
        n_checks++;
        if (st() !== 12'h03C) begin
            n_errors++;
            $display("FAIL timeout_clear: got %h expected %h", st(), 12'h03C);
        end
        pop();
    endtask

    task automatic test_simultaneous();
        logic [7:0] fill [4];
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_frame(fill[i]);
        send_frame(8'h7E);
        // PUSH cycle of 0x7E with the FIFO full: pop in the same cycle.
        ifc.rd_stb = 1'b1;
        tick();
        ifc.rd_stb = 1'b0;
        n_checks++;
        if (st() !== 12'h422) begin
            n_errors++;
            $display("FAIL simul_full_pushpop: got %h expected %h", st(), 12'h422);
        end
        pop();
        pop();
        pop();
        n_checks++;
        if (st() !== 12'h07E) begin
            n_errors++;
            $display("FAIL simul_tail: got %h expected %h", st(), 12'h07E);
        end
        pop();
        // Strobe and abort together mid-frame: abort wins.
        send_bit(1'b1);
        send_bit(1'b1);
        ifc.SDRD     = 1'b1;
        ifc.sd_stb   = 1'b1;
        ifc.sd_abort = 1'b1;
        tick();
        ifc.sd_stb   = 1'b0;
        ifc.sd_abort = 1'b0;
        idle(3);
        n_checks++;
        if (st() !== 12'h900) begin
            n_errors++;
            $display("FAIL simul_abort: got %h expected %h", st(), 12'h900);
        end
        // Error event coincident with err_clr: the event wins.
        send_bit(1'b0);
        ifc.sd_abort = 1'b1;
        ifc.err_clr  = 1'b1;
        tick();
        ifc.sd_abort = 1'b0;
        ifc.err_clr  = 1'b0;
        n_checks++;
        if (st() !== 12'h900) begin
            n_errors++;
            $display("FAIL simul_clr_vs_err: got %h expected %h", st(), 12'h900);
        end
        clear_err();
        // Abort while idle is ignored.
        ifc.sd_abort = 1'b1;
        idle(2);
        ifc.sd_abort = 1'b0;
        n_checks++;
        if (st() !== 12'h800) begin
            n_errors++;
            $display("FAIL idle_abort: got %h expected %h", st(), 12'h800);
        end
        send_frame(8'h5A);
        tick();
        n_checks++;
        if (st() !== 12'h05A) begin
            n_errors++;
            $display("FAIL abort_recover: got %h expected %h", st(), 12'h05A);
        end
        pop();
    endtask

`ifdef SDRD_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        d = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        tick();
        n_checks++;
        if (st() !== 12'h0A5) begin
            n_errors++;
            $display("FAIL parity_good: got %h expected %h", st(), 12'h0A5);
        end
        pop();
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        tick();
        n_checks++;
        if (st() !== 12'h900) begin
            n_errors++;
            $display("FAIL parity_bad: got %h expected %h", st(), 12'h900);
        end
        clear_err();
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        ifc.SDRD     = 1'b0;
        ifc.sd_stb   = 1'b0;
        ifc.sd_abort = 1'b0;
        ifc.rd_stb   = 1'b0;
        ifc.err_clr  = 1'b0;

        test_reset();
        test_frame();
        test_empty_pop();
        test_overflow();
        test_timeout();
        test_simultaneous();
`ifdef SDRD_PARITY_EN
        test_parity();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
